// File: rtl/mvau_inp_buf_ctrl.sv
// MVAU input buffer sequencer.
// Streams SF activation beats into the buffer (write-through, neuron fold 0),
// then replays the stored vector for folds 1..NF-1. Drives the buffer's
// wr_en/rd_en/addr and emits a valid flag plus fold-boundary flags aligned
// with the buffer's registered read data (one cycle after issue).
module mvau_inp_buf_ctrl #(
  parameter int SF       = 16,
  parameter int NF       = 4,
  parameter int BUF_ADDR = 4,
  parameter int NF_W     = (NF > 1) ? $clog2(NF) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_v,
  output logic                in_rdy,
  input  logic                stall,
  output logic                wr_en,
  output logic                rd_en,
  output logic [BUF_ADDR-1:0] addr,
  output logic                out_v,
  output logic                out_sf_last,
  output logic                out_nf_last
);

  typedef enum logic {
    ST_WRITE = 1'b0,
    ST_READ  = 1'b1
  } state_t;

  localparam logic [BUF_ADDR-1:0] SF_LAST = BUF_ADDR'(SF - 1);
  localparam logic [NF_W-1:0]     NF_LAST = NF_W'(NF - 1);

  state_t              state_q, state_d;
  logic [BUF_ADDR-1:0] sf_q, sf_d;
  logic [NF_W-1:0]     nf_q, nf_d;
  logic                out_v_q, out_sf_last_q, out_nf_last_q;

  logic go;       // not in reset and not backpressured: an access may issue
  logic issue;
  logic sf_last;
  logic nf_last;

  assign go      = rst_n & ~stall;
  assign in_rdy  = go & (state_q == ST_WRITE);
  assign wr_en   = in_v & in_rdy;
  assign rd_en   = go & (state_q == ST_READ);
  assign issue   = wr_en | rd_en;
  assign sf_last = (sf_q == SF_LAST);
  assign nf_last = (nf_q == NF_LAST);

  // addr is held at 0 during reset so the buffer never sees a stale index
  assign addr = rst_n ? sf_q : '0;

  // Counter/state advance: only an issued access moves the sequence forward
  always_comb begin
    sf_d    = sf_q;
    nf_d    = nf_q;
    state_d = state_q;
    if (issue) begin
      if (sf_last) begin
        sf_d = '0;
        if (state_q == ST_WRITE) begin
          // With a single neuron fold the write pass is the only pass
          if (NF > 1) begin
            nf_d    = NF_W'(1);
            state_d = ST_READ;
          end
        end else if (nf_last) begin
          nf_d    = '0;
          state_d = ST_WRITE;
        end else begin
          nf_d = nf_q + NF_W'(1);
        end
      end else begin
        sf_d = sf_q + BUF_ADDR'(1);
      end
    end
  end

  // Sequencer registers and issue-aligned output flags (valid one cycle after issue)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_WRITE;
      sf_q          <= '0;
      nf_q          <= '0;
      out_v_q       <= 1'b0;
      out_sf_last_q <= 1'b0;
      out_nf_last_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sf_q          <= sf_d;
      nf_q          <= nf_d;
      out_v_q       <= issue;
      out_sf_last_q <= issue & sf_last;
      out_nf_last_q <= issue & nf_last;
    end
  end

  assign out_v       = out_v_q;
  assign out_sf_last = out_sf_last_q;
  assign out_nf_last = out_nf_last_q;

endmodule

// File: tb/tb_mvau_inp_buf_ctrl.sv
// Directed bench for mvau_inp_buf_ctrl. Three instances (SF4/NF3, SF4/NF2,
// SF3/NF1) share stimulus; each test resets and observes one of them.
// Row vector layout: {in_rdy, wr_en, rd_en, addr[3:0], out_v, out_sf_last, out_nf_last}
module tb_mvau_inp_buf_ctrl;

  logic gclk = 1'b0;
  always #5 gclk = ~gclk;

  logic rst_n, in_v, stall;

  logic       a_rdy, a_wr, a_rd, a_ov, a_sl, a_nl;
  logic [3:0] a_addr;
  logic       b_rdy, b_wr, b_rd, b_ov, b_sl, b_nl;
  logic [3:0] b_addr;
  logic       c_rdy, c_wr, c_rd, c_ov, c_sl, c_nl;
  logic [3:0] c_addr;

  mvau_inp_buf_ctrl #(.SF(4), .NF(3), .BUF_ADDR(4)) u_a (
    .clk(gclk), .rst_n(rst_n), .in_v(in_v), .in_rdy(a_rdy), .stall(stall),
    .wr_en(a_wr), .rd_en(a_rd), .addr(a_addr),
    .out_v(a_ov), .out_sf_last(a_sl), .out_nf_last(a_nl));

  mvau_inp_buf_ctrl #(.SF(4), .NF(2), .BUF_ADDR(4)) u_b (
    .clk(gclk), .rst_n(rst_n), .in_v(in_v), .in_rdy(b_rdy), .stall(stall),
    .wr_en(b_wr), .rd_en(b_rd), .addr(b_addr),
    .out_v(b_ov), .out_sf_last(b_sl), .out_nf_last(b_nl));

  mvau_inp_buf_ctrl #(.SF(3), .NF(1), .BUF_ADDR(4)) u_c (
    .clk(gclk), .rst_n(rst_n), .in_v(in_v), .in_rdy(c_rdy), .stall(stall),
    .wr_en(c_wr), .rd_en(c_rd), .addr(c_addr),
    .out_v(c_ov), .out_sf_last(c_sl), .out_nf_last(c_nl));

  int         sel;
  logic [9:0] obs;
  always_comb begin
    obs = {a_rdy, a_wr, a_rd, a_addr, a_ov, a_sl, a_nl};
    if (sel == 1) obs = {b_rdy, b_wr, b_rd, b_addr, b_ov, b_sl, b_nl};
    if (sel == 2) obs = {c_rdy, c_wr, c_rd, c_addr, c_ov, c_sl, c_nl};
  end

  int n_chk  = 0;
  int n_pass = 0;
  int row_i  = 0;
  int pulses = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  // Apply {rst_n,in_v,stall}, settle, compare, then advance one clock
  task automatic row(input string tag, input logic [2:0] stim, input logic [9:0] exp);
    {rst_n, in_v, stall} = stim;
    #1;
    chk($sformatf("%s[%0d]", tag, row_i), {22'd0, obs}, {22'd0, exp});
    if (obs[2]) pulses++;
    row_i++;
    @(posedge gclk); #1;
  endtask

  task automatic do_reset(input int s);
    sel = s;
    rst_n = 1'b0; in_v = 1'b1; stall = 1'b0;
    repeat (2) @(posedge gclk);
    #1;
    chk("rst", {22'd0, obs}, 32'd0);
    row_i  = 0;
    pulses = 0;
  endtask

  initial begin
    sel = 0; rst_n = 1'b0; in_v = 1'b0; stall = 1'b0;

    // Basic flow SF4/NF3
    do_reset(0);
    row("t1", 3'b110, 10'b1_1_0_0000_0_0_0);
    row("t1", 3'b110, 10'b1_1_0_0001_1_0_0);
    row("t1", 3'b110, 10'b1_1_0_0010_1_0_0);
    row("t1", 3'b110, 10'b1_1_0_0011_1_0_0);
    row("t1", 3'b110, 10'b0_0_1_0000_1_1_0);
    row("t1", 3'b110, 10'b0_0_1_0001_1_0_0);
    row("t1", 3'b110, 10'b0_0_1_0010_1_0_0);
    row("t1", 3'b110, 10'b0_0_1_0011_1_0_0);
    row("t1", 3'b110, 10'b0_0_1_0000_1_1_0);
    row("t1", 3'b110, 10'b0_0_1_0001_1_0_1);
    row("t1", 3'b110, 10'b0_0_1_0010_1_0_1);
    row("t1", 3'b110, 10'b0_0_1_0011_1_0_1);
    row("t1", 3'b100, 10'b1_0_0_0000_1_1_1);
    row("t1", 3'b100, 10'b1_0_0_0000_0_0_0);
    chk("t1_pulses", pulses, 12);

    // Stall three cycles after reading addr 1 of pass nf=1
    do_reset(0);
    row("t2", 3'b110, 10'b1_1_0_0000_0_0_0);
    row("t2", 3'b110, 10'b1_1_0_0001_1_0_0);
    row("t2", 3'b110, 10'b1_1_0_0010_1_0_0);
    row("t2", 3'b110, 10'b1_1_0_0011_1_0_0);
    row("t2", 3'b110, 10'b0_0_1_0000_1_1_0);
    row("t2", 3'b110, 10'b0_0_1_0001_1_0_0);
    row("t2", 3'b111, 10'b0_0_0_0010_1_0_0);
    row("t2", 3'b111, 10'b0_0_0_0010_0_0_0);
    row("t2", 3'b111, 10'b0_0_0_0010_0_0_0);
    row("t2", 3'b110, 10'b0_0_1_0010_0_0_0);
    row("t2", 3'b110, 10'b0_0_1_0011_1_0_0);
    row("t2", 3'b110, 10'b0_0_1_0000_1_1_0);
    row("t2", 3'b110, 10'b0_0_1_0001_1_0_1);
    row("t2", 3'b110, 10'b0_0_1_0010_1_0_1);
    row("t2", 3'b110, 10'b0_0_1_0011_1_0_1);
    row("t2", 3'b100, 10'b1_0_0_0000_1_1_1);
    chk("t2_pulses", pulses, 12);

    // in_v gaps on SF4/NF2: 1,0,0,1,1,0,1
    do_reset(1);
    row("t3", 3'b110, 10'b1_1_0_0000_0_0_0);
    row("t3", 3'b100, 10'b1_0_0_0001_1_0_0);
    row("t3", 3'b100, 10'b1_0_0_0001_0_0_0);
    row("t3", 3'b110, 10'b1_1_0_0001_0_0_0);
    row("t3", 3'b110, 10'b1_1_0_0010_1_0_0);
    row("t3", 3'b100, 10'b1_0_0_0011_1_0_0);
    row("t3", 3'b110, 10'b1_1_0_0011_0_0_0);
    row("t3", 3'b100, 10'b0_0_1_0000_1_1_0);
    row("t3", 3'b100, 10'b0_0_1_0001_1_0_1);
    row("t3", 3'b100, 10'b0_0_1_0010_1_0_1);
    row("t3", 3'b100, 10'b0_0_1_0011_1_0_1);
    row("t3", 3'b100, 10'b1_0_0_0000_1_1_1);

    // NF=1, SF=3: two back-to-back vectors, never reads
    do_reset(2);
    row("t4", 3'b110, 10'b1_1_0_0000_0_0_0);
    row("t4", 3'b110, 10'b1_1_0_0001_1_0_1);
    row("t4", 3'b110, 10'b1_1_0_0010_1_0_1);
    row("t4", 3'b110, 10'b1_1_0_0000_1_1_1);
    row("t4", 3'b110, 10'b1_1_0_0001_1_0_1);
    row("t4", 3'b110, 10'b1_1_0_0010_1_0_1);
    row("t4", 3'b100, 10'b1_0_0_0000_1_1_1);
    chk("t4_pulses", pulses, 6);

    // Reset during the read of addr 2 in pass nf=2
    do_reset(0);
    row("t5", 3'b110, 10'b1_1_0_0000_0_0_0);
    row("t5", 3'b110, 10'b1_1_0_0001_1_0_0);
    row("t5", 3'b110, 10'b1_1_0_0010_1_0_0);
    row("t5", 3'b110, 10'b1_1_0_0011_1_0_0);
    row("t5", 3'b110, 10'b0_0_1_0000_1_1_0);
    row("t5", 3'b110, 10'b0_0_1_0001_1_0_0);
    row("t5", 3'b110, 10'b0_0_1_0010_1_0_0);
    row("t5", 3'b110, 10'b0_0_1_0011_1_0_0);
    row("t5", 3'b110, 10'b0_0_1_0000_1_1_0);
    row("t5", 3'b110, 10'b0_0_1_0001_1_0_1);
    row("t5", 3'b010, 10'b0_0_0_0000_1_0_1);
    row("t5", 3'b110, 10'b1_1_0_0000_0_0_0);
    row("t5", 3'b100, 10'b1_0_0_0001_1_0_0);

    // Stall in WRITE with in_v high holds the address
    do_reset(0);
    row("t6", 3'b110, 10'b1_1_0_0000_0_0_0);
    row("t6", 3'b111, 10'b0_0_0_0001_1_0_0);
    row("t6", 3'b111, 10'b0_0_0_0001_0_0_0);
    row("t6", 3'b110, 10'b1_1_0_0001_0_0_0);
    row("t6", 3'b100, 10'b1_0_0_0010_1_0_0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
